// File: rtl/x_adc_frame_ctrl.sv
// x_adc_frame_ctrl
// Frame sequencer for the multi-channel ADC front end. It accepts a frame on
// srdyi and loads the capture bank. It then walks ch_sel across the captured
// channels so that one shared MAC can process them serially. It waits MAC_LAT
// cycles for the MAC pipeline to drain and then pulses srdyo.
//
// Ports
//   clk          system clock, rising edge
//   GlobalReset  asynchronous active-low reset
//   srdyi        new ADC frame present this cycle
//   overrun_clr  clears the sticky overrun flag
//   capture_en   capture bank load enable (combinational from srdyi)
//   ch_sel       registered channel index into the capture bank
//   mac_en       MAC accumulates the selected channel
//   mac_clr      MAC restarts accumulation (first channel)
//   mac_last     selected channel is the last of the frame
//   srdyo        one-cycle pulse, frame result valid
//   busy         a frame is in flight
//   overrun      sticky, an srdyi arrived while a frame was in flight
//   frame_cnt    completed-frame counter, wraps at 2^16
module x_adc_frame_ctrl #(
    parameter int NUM_CH  = 32,
    parameter int CH_W    = 5,
    parameter int MAC_LAT = 2
) (
    input  logic            clk,
    input  logic            GlobalReset,
    input  logic            srdyi,
    input  logic            overrun_clr,
    output logic            capture_en,
    output logic [CH_W-1:0] ch_sel,
    output logic            mac_en,
    output logic            mac_clr,
    output logic            mac_last,
    output logic            srdyo,
    output logic            busy,
    output logic            overrun,
    output logic [15:0]     frame_cnt
);

    localparam int DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int DRAIN_LOAD = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            ovr_q, ovr_set;
    logic [15:0]     frame_cnt_q;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        drain_d    = drain_q;
        capture_en = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        mac_last   = 1'b0;
        srdyo      = 1'b0;
        ovr_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (srdyi) begin
                    // Gated by reset so the bank never loads while the controller is held.
                    capture_en = GlobalReset;
                    state_d    = RUN;
                    ch_d       = '0;
                end
            end
            RUN: begin
                mac_en   = 1'b1;
                mac_clr  = (ch_q == '0);
                mac_last = (ch_q == LAST_CH);
                ovr_set  = srdyi;
                if (ch_q == LAST_CH) begin
                    // ch_sel is left on the last channel and held outside RUN.
                    if (MAC_LAT == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DW'(DRAIN_LOAD);
                    end
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            DRAIN: begin
                ovr_set = srdyi;
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            DONE: begin
                srdyo = 1'b1;
                if (srdyi) begin
                    capture_en = GlobalReset;
                    state_d    = RUN;
                    ch_d       = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            drain_q     <= '0;
            ovr_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            drain_q <= drain_d;
            // Set has priority over clear.
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (overrun_clr) begin
                ovr_q <= 1'b0;
            end
            if (state_q == DONE) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign ch_sel    = ch_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_x_adc_frame_ctrl.sv
module tb_x_adc_frame_ctrl;

    logic        clk = 1'b0;
    logic        GlobalReset = 1'b0;
    logic        srdyi = 1'b0;
    logic        overrun_clr = 1'b0;

    logic        a_cap, a_en, a_clr, a_last, a_srdyo, a_busy, a_ovr;
    logic [4:0]  a_ch;
    logic [15:0] a_cnt;

    logic        b_cap, b_en, b_clr, b_last, b_srdyo, b_busy, b_ovr;
    logic [1:0]  b_ch;
    logic [15:0] b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    x_adc_frame_ctrl dut (
        .clk(clk), .GlobalReset(GlobalReset), .srdyi(srdyi), .overrun_clr(overrun_clr),
        .capture_en(a_cap), .ch_sel(a_ch), .mac_en(a_en), .mac_clr(a_clr),
        .mac_last(a_last), .srdyo(a_srdyo), .busy(a_busy), .overrun(a_ovr),
        .frame_cnt(a_cnt)
    );

    x_adc_frame_ctrl #(.NUM_CH(4), .CH_W(2), .MAC_LAT(0)) dut4 (
        .clk(clk), .GlobalReset(GlobalReset), .srdyi(srdyi), .overrun_clr(overrun_clr),
        .capture_en(b_cap), .ch_sel(b_ch), .mac_en(b_en), .mac_clr(b_clr),
        .mac_last(b_last), .srdyo(b_srdyo), .busy(b_busy), .overrun(b_ovr),
        .frame_cnt(b_cnt)
    );

    // Leaves the bench at posedge+1 of cycle 0 after reset release.
    task automatic do_reset();
        GlobalReset = 1'b0;
        srdyi = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        GlobalReset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        GlobalReset = 1'b0;
        srdyi = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_cap, a_ch, a_en, a_clr, a_last, a_srdyo, a_busy, a_ovr, a_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=0", {a_cap, a_ch, a_en, a_clr, a_last, a_srdyo, a_busy, a_ovr, a_cnt});
        end
        checks++;
        if ({b_cap, b_ch, b_en, b_clr, b_last, b_srdyo, b_busy, b_ovr, b_cnt} !== 25'h0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=0", {b_cap, b_ch, b_en, b_clr, b_last, b_srdyo, b_busy, b_ovr, b_cnt});
        end
    endtask

    task automatic test_single_frame();
        logic [5:0] obs, exp;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            srdyi = (c == 10);
            @(negedge clk);
            obs = {a_cap, a_busy, a_en, a_clr, a_last, a_srdyo};
            exp = {c == 10, c >= 11 && c <= 45, c >= 11 && c <= 42, c == 11, c == 42, c == 45};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_ctl c=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c >= 11 && c <= 42) begin
                checks++;
                if (a_ch !== 5'(c - 11)) begin
                    errors++;
                    $display("FAIL single_ch c=%0d got=%0d exp=%0d", c, a_ch, c - 11);
                end
            end
            next_cycle();
        end
        srdyi = 1'b0;
        checks++;
        if (a_cnt !== 16'd1 || a_ovr !== 1'b0) begin
            errors++;
            $display("FAIL single_end cnt=%0d ovr=%b exp cnt=1 ovr=0", a_cnt, a_ovr);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs, exp;
        do_reset();
        for (int c = 0; c <= 85; c++) begin
            srdyi = (c == 10 || c == 45);
            @(negedge clk);
            obs = {a_cap, a_busy, a_en, a_clr, a_last, a_srdyo};
            exp = {c == 10 || c == 45,
                   c >= 11 && c <= 80,
                   (c >= 11 && c <= 42) || (c >= 46 && c <= 77),
                   c == 11 || c == 46,
                   c == 42 || c == 77,
                   c == 45 || c == 80};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_ctl c=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 46 || c == 60) begin
                checks++;
                if (a_ch !== 5'(c - 46)) begin
                    errors++;
                    $display("FAIL b2b_ch c=%0d got=%0d exp=%0d", c, a_ch, c - 46);
                end
            end
            next_cycle();
        end
        srdyi = 1'b0;
        checks++;
        if (a_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_cnt got=%0d exp=2", a_cnt);
        end
    endtask

    task automatic test_overrun();
        logic [2:0] obs, exp;
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            srdyi = (c == 10 || c == 20 || c == 60 || c == 70);
            overrun_clr = (c == 50 || c == 70);
            @(negedge clk);
            obs = {a_cap, a_srdyo, a_ovr};
            exp = {c == 10 || c == 60,
                   c == 45 || c == 95,
                   (c >= 21 && c <= 50) || c >= 71};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL overrun c=%0d got=%b exp=%b", c, obs, exp);
            end
            next_cycle();
        end
        srdyi = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int c = 0; c < 25; c++) begin
            srdyi = (c == 10 || c == 20);
            @(negedge clk);
            if (c == 24) begin
                checks++;
                if (a_busy !== 1'b1 || a_ovr !== 1'b1 || a_ch !== 5'd13) begin
                    errors++;
                    $display("FAIL pre_reset busy=%b ovr=%b ch=%0d exp busy=1 ovr=1 ch=13", a_busy, a_ovr, a_ch);
                end
            end
            next_cycle();
        end
        srdyi = 1'b0;
        #3;
        GlobalReset = 1'b0;
        #1;
        checks++;
        if ({a_cap, a_ch, a_en, a_clr, a_last, a_srdyo, a_busy, a_ovr, a_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {a_cap, a_ch, a_en, a_clr, a_last, a_srdyo, a_busy, a_ovr, a_cnt});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (a_srdyo !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL in_reset srdyo=%b busy=%b exp 0 0", a_srdyo, a_busy);
            end
        end
        GlobalReset = 1'b1;
        next_cycle();
        for (int c = 0; c <= 45; c++) begin
            srdyi = (c == 5);
            @(negedge clk);
            checks++;
            if (a_srdyo !== (c == 40)) begin
                errors++;
                $display("FAIL after_reset_srdyo c=%0d got=%b exp=%b", c, a_srdyo, c == 40);
            end
            if (c == 6 || c == 20) begin
                checks++;
                if (a_ch !== 5'(c - 6)) begin
                    errors++;
                    $display("FAIL after_reset_ch c=%0d got=%0d exp=%0d", c, a_ch, c - 6);
                end
            end
            next_cycle();
        end
        srdyi = 1'b0;
        checks++;
        if (a_cnt !== 16'd1) begin
            errors++;
            $display("FAIL after_reset_cnt got=%0d exp=1", a_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        next_cycle();
        release dut.frame_cnt_q;
        for (int c = 1; c <= 41; c++) begin
            srdyi = (c == 5);
            @(negedge clk);
            if (c == 3 || c == 40 || c == 41) begin
                checks++;
                if (a_cnt !== ((c == 41) ? 16'h0000 : 16'hFFFF)) begin
                    errors++;
                    $display("FAIL wrap_cnt c=%0d got=%h exp=%h", c, a_cnt, (c == 41) ? 16'h0000 : 16'hFFFF);
                end
            end
            if (c == 40) begin
                checks++;
                if (a_srdyo !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_srdyo got=%b exp=1", a_srdyo);
                end
            end
            next_cycle();
        end
        srdyi = 1'b0;
    endtask

    task automatic test_small_cfg();
        logic [5:0] obs, exp;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            srdyi = (c == 10);
            @(negedge clk);
            obs = {b_cap, b_busy, b_en, b_clr, b_last, b_srdyo};
            exp = {c == 10, c >= 11 && c <= 15, c >= 11 && c <= 14, c == 11, c == 14, c == 15};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL small_ctl c=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c >= 11 && c <= 14) begin
                checks++;
                if (b_ch !== 2'(c - 11)) begin
                    errors++;
                    $display("FAIL small_ch c=%0d got=%0d exp=%0d", c, b_ch, c - 11);
                end
            end
            next_cycle();
        end
        srdyi = 1'b0;
        checks++;
        if (b_cnt !== 16'd1) begin
            errors++;
            $display("FAIL small_cnt got=%0d exp=1", b_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_wrap();
        test_small_cfg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/x_adc_frame_ctrl.md
# x_adc_frame_ctrl

Frame sequencer for the 32-channel ADC front end. It accepts the input-ready strobe `srdyi` and issues the load enable to the 21-bit capture register bank. It then steps a channel index across the captured samples so that one shared MAC processes the 32 channels serially. After the MAC pipeline drains, it raises the output-ready strobe `srdyo`, and it flags any frame that arrives while a frame is still in flight.

## Interface
- `NUM_CH`, 32: channels per frame; must be ≥ 2.
- `CH_W`, 5: channel index width; must satisfy 2^CH_W ≥ NUM_CH.
- `MAC_LAT`, 2: MAC pipeline latency in cycles; may be 0.
- `clk`  in  1  system clock; all logic is rising-edge.
- `GlobalReset`  in  1  asynchronous, active-low reset.
- `srdyi`  in  1  new ADC frame present on `x_adc_*` this cycle.
- `overrun_clr`  in  1  clears the sticky `overrun` flag.
- `capture_en`  out  1  load enable to the capture bank; combinational.
- `ch_sel`  out  CH_W  registered channel index into the captured bank.
- `mac_en`  out  1  MAC accumulates the selected channel this cycle.
- `mac_clr`  out  1  MAC restarts its accumulation with this channel (first channel of the frame).
- `mac_last`  out  1  the selected channel is the last of the frame.
- `srdyo`  out  1  one-cycle pulse: the MAC result for the frame is valid.
- `busy`  out  1  a frame is in flight (any state other than IDLE).
- `overrun`  out  1  sticky: an `srdyi` was dropped.
- `frame_cnt`  out  16  count of completed frames.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset (`GlobalReset` = 0) forces IDLE with every output 0 (`ch_sel` = 0, `frame_cnt` = 0, `overrun` = 0).
- Accepting a frame: `capture_en` = `srdyi` & (state = IDLE or state = DONE). This is Mealy logic, so the capture bank loads on the same edge that the controller samples `srdyi`.
- IDLE or DONE with `srdyi` = 1: next state is RUN and `ch_sel` is set to 0.
- RUN:
  - `mac_en` = 1 on every RUN cycle.
  - `mac_clr` = 1 only when `ch_sel` = 0.
  - `mac_last` = 1 only when `ch_sel` = NUM_CH-1.
  - `ch_sel` increments by 1 each cycle.
  - At `ch_sel` = NUM_CH-1, next state is DRAIN. If MAC_LAT = 0, next state is DONE instead.
- DRAIN: a down-counter is loaded with MAC_LAT-1 on entry and decrements each cycle. When it reaches 0, next state is DONE. `mac_en`, `mac_clr` and `mac_last` are 0 throughout.
- DONE:
  - Lasts exactly one cycle, with `srdyo` = 1.
  - `frame_cnt` increments at the end of the cycle and wraps from 65535 to 0.
  - Next state is RUN if `srdyi` = 1 (back-to-back frame), otherwise IDLE.
- `ch_sel` holds its last value outside RUN. It is reset to 0 only on frame accept.
- Overrun:
  - `srdyi` = 1 while in RUN or DRAIN is dropped: `capture_en` stays 0, so the bank holds its data.
  - The dropped strobe sets `overrun` on the next edge.
  - `overrun_clr` clears the flag. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame aborts the frame immediately: no `srdyo`, and `frame_cnt` is unchanged from 0.

## Timing
- Frame accepted on edge E0.
- RUN occupies cycles E0+1 through E0+NUM_CH: `ch_sel` steps 0 to NUM_CH-1, one channel per cycle.
- DRAIN occupies the next MAC_LAT cycles.
- `srdyo` is high in cycle E0+NUM_CH+MAC_LAT+1, which is 35 cycles after accept at the defaults.
- Minimum `srdyi` spacing without overrun is NUM_CH+MAC_LAT+1 cycles (35 at the defaults), achieved by presenting `srdyi` during DONE.
- `busy` is registered: high from E0+1 through the DONE cycle inclusive. During a back-to-back frame it stays high continuously.
- `capture_en` has zero latency from `srdyi`. Every other output is registered state decode.

## Test plan
- Single frame:
  - Stimulus: reset release, then one `srdyi` pulse in cycle 10.
  - Response: `capture_en` = 1 in cycle 10; `ch_sel` goes 0..31 over cycles 11–42.
  - Response: `mac_clr` only in cycle 11, `mac_last` only in cycle 42, DRAIN in cycles 43–44.
  - Response: `srdyo` = 1 only in cycle 45; `frame_cnt` = 1; `overrun` = 0.
- Back-to-back frames:
  - Stimulus: `srdyi` in cycle 10 and again in cycle 45 (DONE).
  - Response: second `capture_en` in cycle 45 and `ch_sel` = 0 in cycle 46; `busy` never drops.
  - Response: `srdyo` in cycles 45 and 80; `frame_cnt` = 2.
- Overrun:
  - Stimulus: `srdyi` in cycle 10 and cycle 20.
  - Response: no `capture_en` in cycle 20; `overrun` = 1 from cycle 21; the frame still completes with `srdyo` in cycle 45.
  - Stimulus: `overrun_clr` in cycle 50. Response: `overrun` = 0 in cycle 51.
  - Stimulus: `srdyi` in RUN and `overrun_clr` in the same cycle. Response: `overrun` = 1.
- Reset mid-frame:
  - Stimulus: `GlobalReset` low in cycle 25, asynchronously between edges.
  - Response: all outputs read 0 immediately; no `srdyo`.
  - Stimulus: `srdyi` after reset release. Response: the frame runs normally.
- Wrap and parameters:
  - Stimulus: preload `frame_cnt` to 65535 by force, then run one frame. Response: `frame_cnt` = 0.
  - Stimulus: MAC_LAT = 0 and NUM_CH = 4, `srdyi` in cycle 10. Response: `srdyo` in cycle 15.
